// File: rtl/reverse_dabble.sv
// Iterative BCD-to-binary converter (reverse double dabble) with a START/DONE handshake.
// Define REVERSE_DABBLE_ERROR_EN to build the invalid-digit check (ERROR flag, BINARY forced to 0).
module reverse_dabble #(
    parameter int DECIMAL_DIGITS = 2,
    parameter int OUTPUT_WIDTH   = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DECIMAL_DIGITS*4-1:0] BCD,
    input  logic                        START,
    output logic [OUTPUT_WIDTH-1:0]     BINARY,
    output logic                        ERROR,
    output logic                        DONE
);
    localparam int BW = DECIMAL_DIGITS * 4;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                  state;
    logic [BW-1:0]           bcd_w;
    logic [BW-1:0]           bcd_next;
    logic [OUTPUT_WIDTH-1:0] bin_w;
    logic [OUTPUT_WIDTH-1:0] bin_next;
    logic [7:0]              counter;

    // One shift step: the BCD LSB falls into the binary MSB, then each post-shift nybble >= 8 loses 3.
    always_comb begin
        {bcd_next, bin_next} = {bcd_w, bin_w} >> 1;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (bcd_next[i*4+3]) begin
                bcd_next[i*4 +: 4] = bcd_next[i*4 +: 4] - 4'd3;
            end
        end
    end

`ifdef REVERSE_DABBLE_ERROR_EN
    logic err_w;
    logic bcd_invalid;

    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (BCD[i*4 +: 4] > 4'd9) begin
                bcd_invalid = 1'b1;
            end
        end
    end
`else
    assign ERROR = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 8'd0;
            bcd_w   <= '0;
            bin_w   <= '0;
            BINARY  <= '0;
`ifdef REVERSE_DABBLE_ERROR_EN
            err_w   <= 1'b0;
            ERROR   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        bcd_w   <= BCD;
                        bin_w   <= '0;
                        counter <= 8'(OUTPUT_WIDTH);
`ifdef REVERSE_DABBLE_ERROR_EN
                        err_w   <= bcd_invalid;
`endif
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (counter != 8'd0) begin
                        bcd_w   <= bcd_next;
                        bin_w   <= bin_next;
                        counter <= counter - 8'd1;
                    end else begin
                        // Commit edge: the only place the visible outputs change outside reset.
`ifdef REVERSE_DABBLE_ERROR_EN
                        BINARY <= err_w ? '0 : bin_w;
                        ERROR  <= err_w;
`else
                        BINARY <= bin_w;
`endif
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign DONE = !START && (state == IDLE);
endmodule

// File: tb/tb_reverse_dabble.sv
// Self-checking bench for reverse_dabble: behavioural model (decimal arithmetic plus handshake timing)
// checked every cycle, directed literal cases, a D=4/W=14 instance, and a randomized phase.
module tb_reverse_dabble;
    localparam int D  = 2;
    localparam int W  = 7;
    localparam int D4 = 4;
    localparam int W4 = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [D*4-1:0]   bcd;
    logic             start;
    logic [W-1:0]     binary;
    logic             error;
    logic             done;

    logic [D4*4-1:0]  bcd4;
    logic             start4;
    logic [W4-1:0]    binary4;
    logic             error4;
    logic             done4;

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    reverse_dabble #(.DECIMAL_DIGITS(D), .OUTPUT_WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .BCD(bcd), .START(start),
        .BINARY(binary), .ERROR(error), .DONE(done)
    );

    reverse_dabble #(.DECIMAL_DIGITS(D4), .OUTPUT_WIDTH(W4)) u_dut4 (
        .clk(clk), .reset(reset), .BCD(bcd4), .START(start4),
        .BINARY(binary4), .ERROR(error4), .DONE(done4)
    );

    // Weighted decimal value of the nybbles; the algorithm yields this modulo 2^width even for digits > 9.
    function automatic int bcdValue(input logic [31:0] v, input int digits);
        int sum = 0;
        int weight = 1;
        for (int i = 0; i < digits; i++) begin
            sum += int'(v[i*4 +: 4]) * weight;
            weight *= 10;
        end
        return sum;
    endfunction

    function automatic bit anyInvalid(input logic [31:0] v, input int digits);
        for (int i = 0; i < digits; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int expBinary(input logic [31:0] v, input int digits, input int width);
`ifdef REVERSE_DABBLE_ERROR_EN
        if (anyInvalid(v, digits)) return 0;
`endif
        return bcdValue(v, digits) % (1 << width);
    endfunction

    function automatic bit expError(input logic [31:0] v, input int digits);
`ifdef REVERSE_DABBLE_ERROR_EN
        return anyInvalid(v, digits);
`else
        return 1'b0 & anyInvalid(v, digits);
`endif
    endfunction

    function automatic logic [31:0] toBcd(input int n, input int digits);
        logic [31:0] r = '0;
        int k = n;
        for (int i = 0; i < digits; i++) begin
            r[i*4 +: 4] = 4'(k % 10);
            k = k / 10;
        end
        return r;
    endfunction

    // Handshake model: cycles remaining in the conversion, and the result it will commit.
    int           busy = 0;
    logic [W-1:0] m_bin = '0;
    logic         m_err = 1'b0;
    logic [W-1:0] pend_bin;
    logic         pend_err;

    always @(posedge clk) begin
        if (reset) begin
            busy  = 0;
            m_bin = '0;
            m_err = 1'b0;
        end else if (busy == 0) begin
            if (start) begin
                pend_bin = W'(expBinary(32'(bcd), D, W));
                pend_err = expError(32'(bcd), D);
                busy     = W + 1;
            end
        end else begin
            busy--;
            if (busy == 0) begin
                m_bin = pend_bin;
                m_err = pend_err;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            checks++;
            if ({binary, error, done} !== {m_bin, m_err, (!start && busy == 0)}) begin
                errors++;
                $display("[TB] FAIL cycle_compare t=%0t: BINARY=%0d ERROR=%0b DONE=%0b, required BINARY=%0d ERROR=%0b DONE=%0b",
                         $time, binary, error, done, m_bin, m_err, (!start && busy == 0));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // START high for exactly one edge with the given BCD; returns just after that edge.
    task automatic applyStimulus(input logic [D*4-1:0] value);
        @(posedge clk); #1;
        bcd   = value;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: DONE=0 after 60 cycles, required 1", name);
        end
    endtask

    // Exact latency on the wide instance: old value through E14, new value after E15.
    task automatic convert4(input int n, inout int last);
        logic [31:0] v = toBcd(n, D4);
        @(posedge clk); #1;
        bcd4   = v[D4*4-1:0];
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (W4) @(posedge clk);
        #1;
        checkOutput("d4_hold_before_commit", 32'(binary4), 32'(last));
        checkOutput("d4_done_low_busy", 32'(done4), 32'd0);
        @(posedge clk); #1;
        checkOutput("d4_result", 32'(binary4), 32'(expBinary(v, D4, W4)));
        checkOutput("d4_error", 32'(error4), 32'(expError(v, D4)));
        checkOutput("d4_done", 32'(done4), 32'd1);
        last = expBinary(v, D4, W4);
    endtask

    initial begin
        int last4;
        reset  = 1'b1;
        start  = 1'b0;
        bcd    = '0;
        start4 = 1'b0;
        bcd4   = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        compare_en = 1'b1;

        @(negedge clk);
        checkOutput("reset_binary", 32'(binary), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd1);

        // Pin the model against hand-computed values.
        checkOutput("model_99", 32'(expBinary(32'h99, D, W)), 32'd99);
        checkOutput("model_9999", 32'(expBinary(32'h9999, D4, W4)), 32'd9999);
`ifdef REVERSE_DABBLE_ERROR_EN
        checkOutput("model_1A", 32'(expBinary(32'h1A, D, W)), 32'd0);
`else
        checkOutput("model_1A", 32'(expBinary(32'h1A, D, W)), 32'd20);
`endif

        // Wide instance: 9999 with exact 15-edge latency, boundaries, then a random sample.
        last4 = 0;
        convert4(9999, last4);
        convert4(0, last4);
        convert4(1, last4);
        for (int i = 0; i < 60; i++) convert4(int'($urandom_range(0, 9999)), last4);

        applyStimulus(8'h99);
        waitDone("bcd99");
        checkOutput("bcd99_binary", 32'(binary), 32'd99);
        checkOutput("bcd99_error", 32'(error), 32'd0);
        checkOutput("bcd99_done", 32'(done), 32'd1);

        applyStimulus(8'h00);
        waitDone("bcd00");
        checkOutput("bcd00_binary", 32'(binary), 32'd0);
        applyStimulus(8'h10);
        waitDone("bcd10");
        checkOutput("bcd10_binary", 32'(binary), 32'd10);
        repeat (3) @(negedge clk);
        checkOutput("bcd10_hold_idle", 32'(binary), 32'd10);
        applyStimulus(8'h09);
        repeat (4) @(negedge clk);
        checkOutput("bcd10_hold_busy", 32'(binary), 32'd10);
        waitDone("bcd09");
        checkOutput("bcd09_binary", 32'(binary), 32'd9);

        applyStimulus(8'h1A);
        waitDone("bcd1A");
`ifdef REVERSE_DABBLE_ERROR_EN
        checkOutput("bcd1A_binary", 32'(binary), 32'd0);
        checkOutput("bcd1A_error", 32'(error), 32'd1);
`else
        checkOutput("bcd1A_binary", 32'(binary), 32'd20);
        checkOutput("bcd1A_error", 32'(error), 32'd0);
`endif

        // START pulse during CONVERT is ignored.
        applyStimulus(8'h42);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bcd   = 8'h77;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone("bcd42");
        checkOutput("bcd42_binary", 32'(binary), 32'd42);
        repeat (W + 4) @(negedge clk);
        checkOutput("bcd42_no_restart", 32'(binary), 32'd42);
        checkOutput("bcd42_done_after", 32'(done), 32'd1);

        // Reset mid-conversion discards the in-flight 55.
        applyStimulus(8'h55);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_binary", 32'(binary), 32'd0);
        checkOutput("midreset_error", 32'(error), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd1);
        repeat (W + 5) @(negedge clk);
        checkOutput("midreset_no_late_commit", 32'(binary), 32'd0);

        // START held high: back-to-back conversions, DONE stays low.
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            bcd = 8'(toBcd(int'($urandom_range(0, 99)), D));
            @(posedge clk); #1;
        end
        start = 1'b0;
        waitDone("held_start");

        // Randomized phase: START, BCD (valid and raw) and occasional reset every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            bcd   = ($urandom_range(0, 1) == 0) ? 8'(toBcd(int'($urandom_range(0, 99)), D)) : 8'($urandom);
            reset = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        waitDone("random_tail");

        applyStimulus(8'h63);
        waitDone("bcd63");
        checkOutput("bcd63_binary", 32'(binary), 32'd63);

        @(negedge clk);
        compare_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
